burst_trans_splitter_ipa: RTL and testbench
===========================================

Name: burst_trans_splitter_ipa

Overview:
Sits directly downstream of the 2D transfer splitter in the mchan control unit. It takes each 1D transfer (length, TCDM address, external address) and cuts it into bursts. No burst exceeds MCHAN_BURST_LENGTH bytes, and no burst crosses an external-address burst boundary. Each burst goes to the TCDM/EXT command queues with its own addresses and a last-burst flag.

Parameters:
TRANS_SID_WIDTH, 1, transfer SID width
TCDM_ADD_WIDTH, 12, TCDM byte address width
EXT_ADD_WIDTH, 29, external byte address width
MCHAN_BURST_LENGTH, 64, max burst size in bytes; power of two, at least 4
MCHAN_OPC_WIDTH, `MCHAN_OPC_WIDTH, opcode width (mchan defines)
MCHAN_LEN_WIDTH, `MCHAN_LEN_WIDTH, length width (mchan defines); length encoded as bytes-1

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
mchan_req_i  in  1  upstream transfer request
mchan_gnt_o  out  1  upstream grant; transfer accepted when mchan_req_i & mchan_gnt_o
mchan_sid_i  in  TRANS_SID_WIDTH  transfer SID
mchan_opc_i  in  MCHAN_OPC_WIDTH  opcode (TX/RX)
mchan_len_i  in  MCHAN_LEN_WIDTH  transfer length, bytes-1
mchan_inc_i  in  1  incremental transfer flag
mchan_tcdm_add_i  in  TCDM_ADD_WIDTH  TCDM start address
mchan_ext_add_i  in  EXT_ADD_WIDTH  external start address
burst_req_o  out  1  burst request
burst_gnt_i  in  1  downstream grant; burst transferred when burst_req_o & burst_gnt_i
burst_sid_o  out  TRANS_SID_WIDTH  burst SID
burst_opc_o  out  MCHAN_OPC_WIDTH  burst opcode
burst_len_o  out  MCHAN_LEN_WIDTH  burst length, bytes-1
burst_inc_o  out  1  incremental flag
burst_tcdm_add_o  out  TCDM_ADD_WIDTH  burst TCDM address
burst_ext_add_o  out  EXT_ADD_WIDTH  burst external address
burst_last_o  out  1  final burst of the transfer
busy_o  out  1  high while not IDLE

Behaviour:
- FSM states: IDLE and SPLIT. Reset puts the FSM in IDLE.
- Reset values: all payload registers are 0. While rst_i is high, every output is 0, including mchan_gnt_o.
- In IDLE: mchan_gnt_o=1, burst_req_o=0, payload outputs 0, busy_o=0.
- On accept (mchan_req_i & mchan_gnt_o):
  - Register sid, opc, inc and both addresses.
  - Register rem_bytes = mchan_len_i+1, computed at width MCHAN_LEN_WIDTH+1 so 0xFFFF+1 does not overflow.
  - Next state is SPLIT.
- Latency: the first burst_req_o is high one cycle after accept.
- In SPLIT: mchan_gnt_o=0, burst_req_o=1, busy_o=1. Payload is combinational from the registers:
  - to_bnd = MCHAN_BURST_LENGTH - (ext_add mod MCHAN_BURST_LENGTH)
  - chunk = min(rem_bytes, to_bnd)
  - burst_len_o = chunk-1
  - burst_last_o = (chunk == rem_bytes)
  - addresses, sid, opc and inc come straight from the registers.
- Hold rule: while burst_req_o=1 and burst_gnt_i=0, every burst output stays stable. burst_req_o is never dropped without a grant.
- On burst grant, not last:
  - rem_bytes -= chunk
  - ext_add += chunk, wrapping modulo 2^EXT_ADD_WIDTH
  - tcdm_add += chunk, wrapping modulo 2^TCDM_ADD_WIDTH
  - stay in SPLIT; the next burst is presented the following cycle.
- On burst grant, last: go to IDLE. mchan_gnt_o rises the next cycle, so there is exactly one bubble between transfers.
- Boundary is computed on the external address only. The TCDM address advances by the same chunk with no boundary check.
- burst_inc_o is passed through unchanged. Splitting is identical for inc=0.
- A request arriving while in SPLIT is not granted and must be held by upstream.
- Reset mid-transfer: the remaining bursts are dropped. After reset release the FSM is in IDLE and the next cycle grants a new request.

Test Plan:
- Aligned, two bursts: BURST=64, len_i=127, ext=0x100, tcdm=0x000, gnt_i=1 → bursts {len 63, ext 0x100, tcdm 0x000, last 0} then {len 63, ext 0x140, tcdm 0x040, last 1}; then mchan_gnt_o=1.
- Unaligned, three bursts: len_i=99, ext=0x130, tcdm=0x010 → {len 15, ext 0x130, tcdm 0x010}, {len 63, ext 0x140, tcdm 0x020}, {len 19, ext 0x180, tcdm 0x060, last 1}.
- Small transfers:
  - len_i=3, ext=0x13C → one burst, len 3, last 1.
  - len_i=3, ext=0x13E → {len 1, ext 0x13E}, {len 1, ext 0x140, last 1}.
- Backpressure: burst_gnt_i low for 5 cycles mid-transfer → payload is bit-identical every cycle, mchan_gnt_o=0, and no address advance.
- Wrap: EXT_ADD_WIDTH=29, ext=0x1FFFFFF0, len_i=31 → {len 15, ext 0x1FFFFFF0}, {len 15, ext 0x00000000, last 1}.
- Reset mid-transfer: assert rst_i during the second burst of the first scenario → outputs 0 the same cycle. After release: IDLE, no residual bursts, and a new request is accepted.

Source files
------------

// File: rtl/burst_trans_splitter_ipa.sv
// Cuts each 1D transfer into bursts of at most MCHAN_BURST_LENGTH bytes
// that never cross an external-address burst boundary.
`ifndef MCHAN_OPC_WIDTH
`define MCHAN_OPC_WIDTH 2
`endif
`ifndef MCHAN_LEN_WIDTH
`define MCHAN_LEN_WIDTH 16
`endif

module burst_trans_splitter_ipa #(
  parameter int TRANS_SID_WIDTH    = 1,
  parameter int TCDM_ADD_WIDTH     = 12,
  parameter int EXT_ADD_WIDTH      = 29,
  parameter int MCHAN_BURST_LENGTH = 64,
  parameter int MCHAN_OPC_WIDTH    = `MCHAN_OPC_WIDTH,
  parameter int MCHAN_LEN_WIDTH    = `MCHAN_LEN_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mchan_req_i,
  output logic                       mchan_gnt_o,
  input  logic [TRANS_SID_WIDTH-1:0] mchan_sid_i,
  input  logic [MCHAN_OPC_WIDTH-1:0] mchan_opc_i,
  input  logic [MCHAN_LEN_WIDTH-1:0] mchan_len_i,
  input  logic                       mchan_inc_i,
  input  logic [TCDM_ADD_WIDTH-1:0]  mchan_tcdm_add_i,
  input  logic [EXT_ADD_WIDTH-1:0]   mchan_ext_add_i,
  output logic                       burst_req_o,
  input  logic                       burst_gnt_i,
  output logic [TRANS_SID_WIDTH-1:0] burst_sid_o,
  output logic [MCHAN_OPC_WIDTH-1:0] burst_opc_o,
  output logic [MCHAN_LEN_WIDTH-1:0] burst_len_o,
  output logic                       burst_inc_o,
  output logic [TCDM_ADD_WIDTH-1:0]  burst_tcdm_add_o,
  output logic [EXT_ADD_WIDTH-1:0]   burst_ext_add_o,
  output logic                       burst_last_o,
  output logic                       busy_o
);
  localparam int OFF_W = $clog2(MCHAN_BURST_LENGTH);

  // one extra bit so a full-length transfer (len = all ones) fits as a byte count
  typedef logic [MCHAN_LEN_WIDTH:0]   cnt_t;
  typedef logic [MCHAN_LEN_WIDTH-1:0] len_t;
  typedef logic [EXT_ADD_WIDTH-1:0]   ext_t;
  typedef logic [TCDM_ADD_WIDTH-1:0]  tcdm_t;
  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                     state_q, state_d;
  logic [TRANS_SID_WIDTH-1:0] sid_q;
  logic [MCHAN_OPC_WIDTH-1:0] opc_q;
  logic                       inc_q;
  tcdm_t                      tcdm_q;
  ext_t                       ext_q;
  cnt_t                       rem_q;

  cnt_t to_bnd, chunk;
  logic last, accept, bgrant;

  assign to_bnd = cnt_t'(MCHAN_BURST_LENGTH) - cnt_t'(ext_q[OFF_W-1:0]);
  assign chunk  = (rem_q < to_bnd) ? rem_q : to_bnd;
  assign last   = (chunk == rem_q);
  assign accept = mchan_req_i & mchan_gnt_o;
  assign bgrant = burst_req_o & burst_gnt_i;

  always_comb begin
    state_d          = state_q;
    mchan_gnt_o      = 1'b0;
    burst_req_o      = 1'b0;
    busy_o           = 1'b0;
    burst_sid_o      = '0;
    burst_opc_o      = '0;
    burst_len_o      = '0;
    burst_inc_o      = 1'b0;
    burst_tcdm_add_o = '0;
    burst_ext_add_o  = '0;
    burst_last_o     = 1'b0;
    case (state_q)
      IDLE: begin
        // grant is masked while reset is held so nothing is accepted then
        mchan_gnt_o = ~rst_i;
        if (mchan_req_i && !rst_i) state_d = SPLIT;
      end
      SPLIT: begin
        burst_req_o      = 1'b1;
        busy_o           = 1'b1;
        burst_sid_o      = sid_q;
        burst_opc_o      = opc_q;
        burst_len_o      = len_t'(chunk - cnt_t'(1));
        burst_inc_o      = inc_q;
        burst_tcdm_add_o = tcdm_q;
        burst_ext_add_o  = ext_q;
        burst_last_o     = last;
        if (burst_gnt_i && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sid_q   <= '0;
      opc_q   <= '0;
      inc_q   <= 1'b0;
      tcdm_q  <= '0;
      ext_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sid_q  <= mchan_sid_i;
        opc_q  <= mchan_opc_i;
        inc_q  <= mchan_inc_i;
        tcdm_q <= mchan_tcdm_add_i;
        ext_q  <= mchan_ext_add_i;
        rem_q  <= cnt_t'(mchan_len_i) + cnt_t'(1);
      end else if (bgrant && !last) begin
        rem_q  <= rem_q - chunk;
        ext_q  <= ext_q + ext_t'(chunk);
        tcdm_q <= tcdm_q + tcdm_t'(chunk);
      end
    end
  end
endmodule

// File: tb/tb_burst_trans_splitter_ipa.sv
// Random + directed bench for burst_trans_splitter_ipa against a queue-based burst model.
module tb_burst_trans_splitter_ipa;
  localparam int SW = 1, TW = 12, EW = 29, BL = 64, OW = 2, LW = 16;

  typedef struct {
    logic [LW-1:0] len;
    logic [EW-1:0] ext;
    logic [TW-1:0] tcdm;
    logic          last;
    logic [SW-1:0] sid;
    logic [OW-1:0] opc;
    logic          inc;
  } burst_t;

  logic          clk = 1'b0, rst_i = 1'b1;
  logic          mchan_req_i = 1'b0, mchan_gnt_o;
  logic [SW-1:0] mchan_sid_i = '0;
  logic [OW-1:0] mchan_opc_i = '0;
  logic [LW-1:0] mchan_len_i = '0;
  logic          mchan_inc_i = 1'b0;
  logic [TW-1:0] mchan_tcdm_add_i = '0;
  logic [EW-1:0] mchan_ext_add_i = '0;
  logic          burst_req_o, burst_gnt_i = 1'b0;
  logic [SW-1:0] burst_sid_o;
  logic [OW-1:0] burst_opc_o;
  logic [LW-1:0] burst_len_o;
  logic          burst_inc_o;
  logic [TW-1:0] burst_tcdm_add_o;
  logic [EW-1:0] burst_ext_add_o;
  logic          burst_last_o, busy_o;

  int n_checks = 0, n_fail = 0;
  int gnt_mode = 1;  // 0 random, 1 always, 2 never
  burst_t exp_q[$];

  burst_trans_splitter_ipa #(
    .TRANS_SID_WIDTH(SW), .TCDM_ADD_WIDTH(TW), .EXT_ADD_WIDTH(EW),
    .MCHAN_BURST_LENGTH(BL), .MCHAN_OPC_WIDTH(OW), .MCHAN_LEN_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mchan_req_i(mchan_req_i), .mchan_gnt_o(mchan_gnt_o),
    .mchan_sid_i(mchan_sid_i), .mchan_opc_i(mchan_opc_i),
    .mchan_len_i(mchan_len_i), .mchan_inc_i(mchan_inc_i),
    .mchan_tcdm_add_i(mchan_tcdm_add_i), .mchan_ext_add_i(mchan_ext_add_i),
    .burst_req_o(burst_req_o), .burst_gnt_i(burst_gnt_i),
    .burst_sid_o(burst_sid_o), .burst_opc_o(burst_opc_o),
    .burst_len_o(burst_len_o), .burst_inc_o(burst_inc_o),
    .burst_tcdm_add_o(burst_tcdm_add_o), .burst_ext_add_o(burst_ext_add_o),
    .burst_last_o(burst_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: walk the transfer byte count, each burst runs to the next
  // external boundary or to the end of the transfer, whichever is first.
  function automatic void model(input longint unsigned len, input longint unsigned ext,
                                input longint unsigned tcdm, input logic [SW-1:0] sid,
                                input logic [OW-1:0] opc, input logic inc, output burst_t bq[$]);
    longint unsigned rem, e, t, to_b, c;
    burst_t b;
    bq.delete();
    rem = len + 1; e = ext; t = tcdm;
    while (rem > 0) begin
      to_b = BL - (e % BL);
      c = (rem < to_b) ? rem : to_b;
      b.len = LW'(c - 1); b.ext = EW'(e); b.tcdm = TW'(t); b.last = (c == rem);
      b.sid = sid; b.opc = opc; b.inc = inc;
      bq.push_back(b);
      rem -= c;
      e = (e + c) % (64'd1 << EW);
      t = (t + c) % (64'd1 << TW);
    end
  endfunction

  // burst grant driven 2 time units after the edge so mode changes at +1 take effect
  always @(posedge clk) begin
    #2;
    case (gnt_mode)
      0:       burst_gnt_i = ($urandom_range(0, 9) < 7);
      1:       burst_gnt_i = 1'b1;
      default: burst_gnt_i = 1'b0;
    endcase
  end

  // compare process: inputs are stable at negedge for the coming posedge
  logic [127:0] snap, cur;
  logic hold_v = 1'b0;
  always @(negedge clk) begin
    burst_t b, bq[$];
    logic busy_e;
    cur = {burst_req_o, burst_sid_o, burst_opc_o, burst_len_o, burst_inc_o,
           burst_tcdm_add_o, burst_ext_add_o, burst_last_o};
    if (rst_i) begin
      check("reset_outputs", {mchan_gnt_o, busy_o, cur}, '0);
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      busy_e = (exp_q.size() > 0);
      check("busy", busy_o, busy_e);
      check("mchan_gnt", mchan_gnt_o, !busy_e);
      check("burst_req", burst_req_o, busy_e);
      if (hold_v) check("hold_stable", cur, snap);
      if (busy_e) begin
        b = exp_q[0];
        check("burst_len", burst_len_o, b.len);
        check("burst_ext", burst_ext_add_o, b.ext);
        check("burst_tcdm", burst_tcdm_add_o, b.tcdm);
        check("burst_last", burst_last_o, b.last);
        check("burst_sid_opc_inc", {burst_sid_o, burst_opc_o, burst_inc_o}, {b.sid, b.opc, b.inc});
        hold_v = !burst_gnt_i;
        snap = cur;
        if (burst_gnt_i) void'(exp_q.pop_front());
      end else begin
        hold_v = 1'b0;
        check("idle_payload", cur, '0);
        if (mchan_req_i) begin
          model(mchan_len_i, mchan_ext_add_i, mchan_tcdm_add_i, mchan_sid_i,
                mchan_opc_i, mchan_inc_i, bq);
          foreach (bq[i]) exp_q.push_back(bq[i]);
        end
      end
    end
  end

  task automatic send(input int unsigned len, input int unsigned ext, input int unsigned tcdm,
                      input logic [SW-1:0] sid, input logic [OW-1:0] opc, input logic inc);
    logic acc;
    bit done = 0;
    @(posedge clk); #1;
    mchan_req_i = 1'b1; mchan_len_i = LW'(len); mchan_ext_add_i = EW'(ext);
    mchan_tcdm_add_i = TW'(tcdm); mchan_sid_i = sid; mchan_opc_i = opc; mchan_inc_i = inc;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      acc = mchan_req_i & mchan_gnt_o;
      @(posedge clk); #1;
      if (acc) done = 1;
    end
    mchan_req_i = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no grant expected grant within 5000 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d bursts pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    burst_t p[$];
    // hand-computed pins on the model itself
    model(127, 'h100, 'h000, 0, 0, 1, p);
    check("pin_a_n", p.size(), 2);
    check("pin_a_b1", {p[1].len, p[1].ext, p[1].tcdm, p[1].last}, {16'd63, 29'h140, 12'h040, 1'b1});
    model(99, 'h130, 'h010, 0, 0, 1, p);
    check("pin_b_n", p.size(), 3);
    check("pin_b_b0", {p[0].len, p[0].ext, p[0].tcdm, p[0].last}, {16'd15, 29'h130, 12'h010, 1'b0});
    check("pin_b_b1", {p[1].len, p[1].ext, p[1].tcdm, p[1].last}, {16'd63, 29'h140, 12'h020, 1'b0});
    check("pin_b_b2", {p[2].len, p[2].ext, p[2].tcdm, p[2].last}, {16'd19, 29'h180, 12'h060, 1'b1});
    model(3, 'h13C, 0, 0, 0, 1, p);
    check("pin_c", {p.size(), p[0].len, p[0].last}, {32'd1, 16'd3, 1'b1});
    model(3, 'h13E, 0, 0, 0, 1, p);
    check("pin_d", {p.size(), p[0].len, p[1].len, p[1].ext, p[1].last}, {32'd2, 16'd1, 16'd1, 29'h140, 1'b1});
    model(31, 'h1FFFFFF0, 0, 0, 0, 1, p);
    check("pin_wrap", {p[0].len, p[0].ext, p[1].len, p[1].ext, p[1].last},
          {16'd15, 29'h1FFFFFF0, 16'd15, 29'h0, 1'b1});

    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // directed scenarios
    gnt_mode = 1;
    send(127, 'h100, 'h000, 1, 2'd1, 1'b1); wait_idle();
    send(99, 'h130, 'h010, 0, 2'd2, 1'b1);
    send(3, 'h13C, 'h020, 1, 2'd0, 1'b1);
    send(3, 'h13E, 'h030, 0, 2'd3, 1'b0);
    send(31, 'h1FFFFFF0, 'hFF8, 1, 2'd1, 1'b0);
    wait_idle();

    // backpressure for 5 cycles mid-transfer
    send(199, 'h210, 'h100, 1, 2'd2, 1'b1);
    @(posedge clk); #1;
    gnt_mode = 2;
    repeat (5) @(posedge clk);
    #1 gnt_mode = 1;
    wait_idle();

    // reset during the second burst, then a fresh request
    send(127, 'h100, 'h000, 0, 2'd1, 1'b1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    send(3, 'h13C, 'h004, 1, 2'd2, 1'b0);
    wait_idle();

    // randomized, back-to-back so requests also arrive during SPLIT
    gnt_mode = 0;
    for (int k = 0; k < 60; k++) begin
      int unsigned len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 300);
      send(len, $urandom, $urandom, SW'($urandom), OW'($urandom), 1'($urandom));
    end
    send(16'hFFFF, 'h1FFFFFC3, 'h7, 1, 2'd3, 1'b1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
